// File: rtl/pdl_step_ctrl_pkg.sv
// Shared types and helpers for the PDL tap-enable step controller.
package pdl_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_SETTLE = 2'd2
  } ch_state_e;

  localparam logic MODE_RAMP   = 1'b0;
  localparam logic MODE_DIRECT = 1'b1;

  // Largest supported line; callers size-cast the result down to their tap count.
  localparam int MAX_TAPS   = 256;
  localparam int MAX_CODE_W = 9;

  function automatic logic [MAX_TAPS-1:0] therm_enc(input logic [MAX_CODE_W-1:0] code);
    logic [MAX_TAPS-1:0] t;
    for (int i = 0; i < MAX_TAPS; i++) t[i] = (i < int'(code));
    return t;
  endfunction

endpackage

// File: rtl/pdl_step_ctrl_if.sv
// Request channel of the PDL step controller.
// Handshake: a request transfers on a rising clk edge where cfg_valid && cfg_ready; cfg_ch/cfg_code/cfg_mode must be stable while cfg_valid is high.
interface pdl_step_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CODE_W = 7
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CODE_W-1:0] cfg_code;
  logic              cfg_mode;

  modport master (output cfg_valid, cfg_ch, cfg_code, cfg_mode, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_code, cfg_mode, output cfg_ready);
endinterface

// File: rtl/pdl_step_ctrl_stepper.sv
// One delay line: walks cur_code toward the latched target with a settle gap after every tap change.
module pdl_ch_stepper
  import pdl_ctrl_pkg::*;
#(
  parameter int NUM_TAPS   = 64,
  parameter int CODE_W     = 7,
  parameter int SETTLE_CYC = 4,
  parameter int RESET_CODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                freeze,
  input  logic                start,
  input  logic [CODE_W-1:0]   start_code,
  input  logic                start_mode,
  output logic                busy,
  output logic                done,
  output logic [CODE_W-1:0]   cur_code,
  output logic [NUM_TAPS-1:0] bk,
  output ch_state_e           state
);

  logic [CODE_W-1:0] target;
  logic              mode;
  logic [7:0]        cnt;
  logic [CODE_W-1:0] step_tgt;
  logic              step_mode;
  logic              step_now;
  logic [CODE_W-1:0] next_code;

  // The accepting edge performs the first compare/step, so an already-equal request completes one cycle later.
  always_comb begin
    step_now  = (state == ST_CHECK) || (state == ST_IDLE && start);
    step_tgt  = (state == ST_IDLE) ? start_code : target;
    step_mode = (state == ST_IDLE) ? start_mode : mode;
    if (step_mode == MODE_DIRECT)  next_code = step_tgt;
    else if (cur_code < step_tgt)  next_code = cur_code + CODE_W'(1);
    else                           next_code = cur_code - CODE_W'(1);
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      target   <= CODE_W'(RESET_CODE);
      mode     <= MODE_RAMP;
      cnt      <= '0;
      done     <= 1'b0;
      cur_code <= CODE_W'(RESET_CODE);
      bk       <= NUM_TAPS'(therm_enc(MAX_CODE_W'(RESET_CODE)));
    end else if (freeze) begin
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE && start) begin
        target <= start_code;
        mode   <= start_mode;
      end
      if (state == ST_SETTLE) begin
        if (cnt == 8'(SETTLE_CYC - 1)) state <= ST_CHECK;
        else                           cnt   <= cnt + 8'd1;
      end else if (step_now) begin
        if (cur_code == step_tgt) begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end else begin
          cur_code <= next_code;
          bk       <= NUM_TAPS'(therm_enc(MAX_CODE_W'(next_code)));
          cnt      <= '0;
          state    <= ST_SETTLE;
        end
      end
    end
  end

endmodule

// File: rtl/pdl_step_ctrl.sv
// Multi-channel PDL tap-enable controller: request decode, code clamp and per-channel steppers.
module pdl_step_ctrl
  import pdl_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int NUM_TAPS   = 64,
  parameter int CODE_W     = $clog2(NUM_TAPS + 1),
  parameter int SETTLE_CYC = 4,
  parameter int RESET_CODE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pdl_step_ctrl_if.slave               cfg,
  input  logic                         freeze,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            done,
  output logic                         cfg_err,
  output logic [NUM_CH*CODE_W-1:0]     cur_code,
  output logic [NUM_CH*NUM_TAPS-1:0]   bk,
  output logic [NUM_CH*2-1:0]          dbg_state
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              sel_busy;
  logic              ch_ok;
  logic              accept;
  logic              over;
  logic [CODE_W-1:0] tgt;

  always_comb begin
    sel_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (cfg.cfg_ch == CH_W'(c)) sel_busy = busy[c];
  end

  // Out-of-range channel numbers are never ready, so they can never be accepted.
  assign ch_ok         = {1'b0, cfg.cfg_ch} < (CH_W + 1)'(NUM_CH);
  assign cfg.cfg_ready = !freeze && !sel_busy && ch_ok;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign over          = cfg.cfg_code > CODE_W'(NUM_TAPS);
  assign tgt           = over ? CODE_W'(NUM_TAPS) : cfg.cfg_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= accept && over;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_e st;

    pdl_ch_stepper #(
      .NUM_TAPS   (NUM_TAPS),
      .CODE_W     (CODE_W),
      .SETTLE_CYC (SETTLE_CYC),
      .RESET_CODE (RESET_CODE)
    ) u_step (
      .clk        (clk),
      .rst_n      (rst_n),
      .freeze     (freeze),
      .start      (accept && (cfg.cfg_ch == CH_W'(c))),
      .start_code (tgt),
      .start_mode (cfg.cfg_mode),
      .busy       (busy[c]),
      .done       (done[c]),
      .cur_code   (cur_code[c*CODE_W +: CODE_W]),
      .bk         (bk[c*NUM_TAPS +: NUM_TAPS]),
      .state      (st)
    );

    assign dbg_state[c*2 +: 2] = st;
  end

endmodule

// File: tb/tb_pdl_step_ctrl.sv
// Directed bench for pdl_step_ctrl: 4 channels, 64 taps, settle 4, reset code 8.
module tb_pdl_step_ctrl;

  localparam int NC = 4;
  localparam int NT = 64;
  localparam int CW = 7;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               freeze = 1'b0;
  logic [NC-1:0]      busy;
  logic [NC-1:0]      done;
  logic               cfg_err;
  logic [NC*CW-1:0]   cur_code;
  logic [NC*NT-1:0]   bk;
  logic [NC*2-1:0]    dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [CW-1:0] exp_q[$];

  pdl_step_ctrl_if #(.NUM_CH(NC), .CODE_W(CW)) cfg ();

  pdl_step_ctrl #(
    .NUM_CH(NC), .NUM_TAPS(NT), .CODE_W(CW), .SETTLE_CYC(4), .RESET_CODE(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg), .freeze(freeze), .busy(busy), .done(done),
    .cfg_err(cfg_err), .cur_code(cur_code), .bk(bk), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cur_of(input int c);
    return cur_code[c*CW +: CW];
  endfunction

  function automatic logic [NT-1:0] bk_of(input int c);
    return bk[c*NT +: NT];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge (cycle 1 of the request).
  task automatic do_accept(input int ch, input int code, input logic mode);
    int waited = 0;
    cfg.cfg_ch    = 2'(ch);
    cfg.cfg_code  = 7'(code);
    cfg.cfg_mode  = mode;
    cfg.cfg_valid = 1'b1;
    #1;
    while (!cfg.cfg_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!cfg.cfg_ready) begin
      n_total++;
      $display("FAIL accept_timeout ch=%0d ready=%b exp=1", ch, cfg.cfg_ready);
      cfg.cfg_valid = 1'b0;
    end else begin
      tick();
      cfg.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    cfg.cfg_valid = 1'b0; cfg.cfg_ch = '0; cfg.cfg_code = '0; cfg.cfg_mode = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int c = 0; c < NC; c++) begin
      n_total++; if (cur_of(c) !== 7'd8) $display("FAIL reset_cur ch=%0d got=%0d exp=8", c, cur_of(c)); else n_pass++;
      n_total++; if (bk_of(c) !== 64'hFF) $display("FAIL reset_bk ch=%0d got=%h exp=ff", c, bk_of(c)); else n_pass++;
    end
    n_total++; if (busy !== 4'b0) $display("FAIL reset_busy got=%b exp=0000", busy); else n_pass++;
    n_total++; if (done !== 4'b0) $display("FAIL reset_done got=%b exp=0000", done); else n_pass++;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", cfg_err); else n_pass++;
    n_total++; if (cfg.cfg_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cfg.cfg_ready); else n_pass++;
    n_total++; if (dbg_state !== 8'h00) $display("FAIL reset_state got=%h exp=00", dbg_state); else n_pass++;
  endtask

  task automatic test_ramp();
    logic [CW-1:0] e;
    do_accept(0, 0, 1'b1);
    n_total++; if (cur_of(0) !== 7'd0) $display("FAIL pre_direct_cur got=%0d exp=0", cur_of(0)); else n_pass++;
    n_total++; if (busy[0] !== 1'b1) $display("FAIL pre_direct_busy got=%b exp=1", busy[0]); else n_pass++;
    repeat (5) tick();
    n_total++; if (done[0] !== 1'b1) $display("FAIL pre_direct_done got=%b exp=1", done[0]); else n_pass++;
    do_accept(0, 3, 1'b0);
    for (int k = 0; k < 5; k++) exp_q.push_back(7'd1);
    for (int k = 0; k < 5; k++) exp_q.push_back(7'd2);
    for (int k = 0; k < 6; k++) exp_q.push_back(7'd3);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      e = exp_q.pop_front();
      n_total++; if (cur_of(0) !== e) $display("FAIL ramp_cur cyc=%0d got=%0d exp=%0d", cyc, cur_of(0), e); else n_pass++;
      n_total++; if (done[0] !== (cyc == 16)) $display("FAIL ramp_done cyc=%0d got=%b exp=%b", cyc, done[0], cyc == 16); else n_pass++;
      if (cyc < 16) tick();
    end
    n_total++; if (busy[0] !== 1'b0) $display("FAIL ramp_busy_end got=%b exp=0", busy[0]); else n_pass++;
    n_total++; if (bk_of(0) !== 64'h7) $display("FAIL ramp_bk got=%h exp=7", bk_of(0)); else n_pass++;
    tick();
    n_total++; if (done[0] !== 1'b0) $display("FAIL ramp_done_pulse got=%b exp=0", done[0]); else n_pass++;
  endtask

  task automatic test_direct();
    do_accept(1, 40, 1'b1);
    n_total++; if (cur_of(1) !== 7'd40) $display("FAIL direct_cur got=%0d exp=40", cur_of(1)); else n_pass++;
    n_total++; if (bk_of(1) !== 64'h000000FFFFFFFFFF) $display("FAIL direct_bk got=%h exp=000000ffffffffff", bk_of(1)); else n_pass++;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL direct_err got=%b exp=0", cfg_err); else n_pass++;
    repeat (4) tick();
    n_total++; if (done[1] !== 1'b0) $display("FAIL direct_done_c5 got=%b exp=0", done[1]); else n_pass++;
    tick();
    n_total++; if (done[1] !== 1'b1) $display("FAIL direct_done_c6 got=%b exp=1", done[1]); else n_pass++;
    do_accept(1, 38, 1'b0);
    n_total++; if (cur_of(1) !== 7'd39) $display("FAIL down_cur_c1 got=%0d exp=39", cur_of(1)); else n_pass++;
    repeat (9) tick();
    n_total++; if (done[1] !== 1'b0) $display("FAIL down_done_c10 got=%b exp=0", done[1]); else n_pass++;
    tick();
    n_total++; if (done[1] !== 1'b1) $display("FAIL down_done_c11 got=%b exp=1", done[1]); else n_pass++;
    n_total++; if (cur_of(1) !== 7'd38) $display("FAIL down_cur_end got=%0d exp=38", cur_of(1)); else n_pass++;
    n_total++; if (bk_of(1) !== 64'h0000003FFFFFFFFF) $display("FAIL down_bk got=%h exp=0000003fffffffff", bk_of(1)); else n_pass++;
  endtask

  task automatic test_clamp();
    do_accept(0, 100, 1'b1);
    n_total++; if (cfg_err !== 1'b1) $display("FAIL clamp_err_c1 got=%b exp=1", cfg_err); else n_pass++;
    n_total++; if (cur_of(0) !== 7'd64) $display("FAIL clamp_cur got=%0d exp=64", cur_of(0)); else n_pass++;
    n_total++; if (bk_of(0) !== {64{1'b1}}) $display("FAIL clamp_bk got=%h exp=all ones", bk_of(0)); else n_pass++;
    tick();
    n_total++; if (cfg_err !== 1'b0) $display("FAIL clamp_err_c2 got=%b exp=0", cfg_err); else n_pass++;
    repeat (4) tick();
    n_total++; if (done[0] !== 1'b1) $display("FAIL clamp_done_c6 got=%b exp=1", done[0]); else n_pass++;
    do_accept(0, 64, 1'b0);
    n_total++; if (done[0] !== 1'b1) $display("FAIL equal_done_c1 got=%b exp=1", done[0]); else n_pass++;
    n_total++; if (busy[0] !== 1'b0) $display("FAIL equal_busy got=%b exp=0", busy[0]); else n_pass++;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL equal_err got=%b exp=0", cfg_err); else n_pass++;
    n_total++; if (bk_of(0) !== {64{1'b1}}) $display("FAIL equal_bk got=%h exp=all ones", bk_of(0)); else n_pass++;
  endtask

  task automatic test_freeze();
    do_accept(2, 0, 1'b1);
    repeat (5) tick();
    n_total++; if (done[2] !== 1'b1) $display("FAIL frz_pre_done got=%b exp=1", done[2]); else n_pass++;
    do_accept(2, 2, 1'b0);
    n_total++; if (cur_of(2) !== 7'd1) $display("FAIL frz_cur_c1 got=%0d exp=1", cur_of(2)); else n_pass++;
    tick(); tick();
    freeze = 1'b1;
    cfg.cfg_ch = 2'd1;
    #1;
    for (int k = 0; k < 10; k++) begin
      n_total++; if (cfg.cfg_ready !== 1'b0) $display("FAIL frz_ready k=%0d got=%b exp=0", k, cfg.cfg_ready); else n_pass++;
      tick();
      n_total++; if (cur_of(2) !== 7'd1) $display("FAIL frz_hold_cur k=%0d got=%0d exp=1", k, cur_of(2)); else n_pass++;
      n_total++; if (dbg_state[5:4] !== 2'd2) $display("FAIL frz_hold_state k=%0d got=%0d exp=2", k, dbg_state[5:4]); else n_pass++;
    end
    freeze = 1'b0;
    tick();
    cfg.cfg_ch = 2'd2; cfg.cfg_code = 7'd10; cfg.cfg_mode = 1'b1; cfg.cfg_valid = 1'b1;
    #1;
    n_total++; if (cfg.cfg_ready !== 1'b0) $display("FAIL stall_ready got=%b exp=0", cfg.cfg_ready); else n_pass++;
    tick();
    cfg.cfg_valid = 1'b0;
    n_total++; if (cur_of(2) !== 7'd1) $display("FAIL stall_cur_c15 got=%0d exp=1", cur_of(2)); else n_pass++;
    tick();
    n_total++; if (cur_of(2) !== 7'd2) $display("FAIL frz_cur_c16 got=%0d exp=2", cur_of(2)); else n_pass++;
    repeat (4) tick();
    n_total++; if (done[2] !== 1'b0) $display("FAIL frz_done_c20 got=%b exp=0", done[2]); else n_pass++;
    tick();
    n_total++; if (done[2] !== 1'b1) $display("FAIL frz_done_c21 got=%b exp=1", done[2]); else n_pass++;
    n_total++; if (bk_of(2) !== 64'h3) $display("FAIL frz_bk got=%h exp=3", bk_of(2)); else n_pass++;
  endtask

  task automatic test_back_to_back_reset();
    do_accept(3, 0, 1'b0);
    n_total++; if (cur_of(3) !== 7'd7) $display("FAIL b2b_ch3_c1 got=%0d exp=7", cur_of(3)); else n_pass++;
    do_accept(1, 0, 1'b1);
    n_total++; if (cur_of(1) !== 7'd0) $display("FAIL b2b_ch1_cur got=%0d exp=0", cur_of(1)); else n_pass++;
    n_total++; if (busy[3] !== 1'b1 || busy[1] !== 1'b1) $display("FAIL b2b_busy got=%b exp=1x1x", busy); else n_pass++;
    repeat (9) tick();
    n_total++; if (cur_of(3) !== 7'd5) $display("FAIL mid_cur_c11 got=%0d exp=5", cur_of(3)); else n_pass++;
    tick();
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      n_total++; if (cur_of(c) !== 7'd8) $display("FAIL async_rst_cur ch=%0d got=%0d exp=8", c, cur_of(c)); else n_pass++;
    end
    n_total++; if (busy !== 4'b0) $display("FAIL async_rst_busy got=%b exp=0000", busy); else n_pass++;
    n_total++; if (bk_of(3) !== 64'hFF) $display("FAIL async_rst_bk got=%h exp=ff", bk_of(3)); else n_pass++;
    n_total++; if (dbg_state !== 8'h00) $display("FAIL async_rst_state got=%h exp=00", dbg_state); else n_pass++;
    #1 rst_n = 1'b1;
    tick();
    do_accept(3, 20, 1'b1);
    n_total++; if (cur_of(3) !== 7'd20) $display("FAIL post_rst_cur got=%0d exp=20", cur_of(3)); else n_pass++;
    repeat (5) tick();
    n_total++; if (done[3] !== 1'b1) $display("FAIL post_rst_done got=%b exp=1", done[3]); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t exp=finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_direct();
    test_clamp();
    test_freeze();
    test_back_to_back_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
